// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sequencer state type, address constants and a width helper
package cpu_pkg;
    typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH, HALT} seq_state_t;
    localparam int ADDR_W   = 32;
    localparam int PC_START = 212;
    localparam int PC_END   = 255;
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/seq_wait_counter.sv
// seq_wait_counter: loadable up/down wait counter with last (==1) and terminal (==TERM) flags
//   load/load_val : preset count (highest priority after reset)
//   dec / inc     : count down / up by one
//   cnt           : current count; last: cnt==1; term: cnt==TERM
module seq_wait_counter #(
    parameter int W    = 2,
    parameter int TERM = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         last,
    output logic         term
);
    always_ff @(posedge clk)
        if (reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec) cnt <= cnt - W'(1);
        else if (inc) cnt <= cnt + W'(1);
    assign last = cnt == W'(1);
    assign term = cnt == W'(TERM);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: decides per cycle whether the PC advances, holds for memory, or loads a branch target
//   in : clk, reset, pc_in, branch, zero, offset, mem_req, mem_ready
//   out: pc_en (PC+1), pc_load (PC<=pc_target), pc_target, stall, flush, halted, timeout_err
module pc_sequencer import cpu_pkg::*; #(
    parameter int ADDR_W           = cpu_pkg::ADDR_W,
    parameter int PC_END_ADDRESS   = cpu_pkg::PC_END,
    parameter int USE_READY        = 0,
    parameter int MEM_LATENCY      = 3,
    parameter int MAX_WAIT         = 16,
    parameter int FLUSH_CYCLES     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              branch,
    input  logic              zero,
    input  logic [ADDR_W-1:0] offset,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              stall,
    output logic              flush,
    output logic              halted,
    output logic              timeout_err
);
    localparam int CW = $clog2(max3(MEM_LATENCY, MAX_WAIT, FLUSH_CYCLES) + 1);
    seq_state_t state, nxt;
    logic mem_served, tmo_q;
    logic ld, dec, inc, last, term, set_srv, clr_srv, set_to;
    logic [CW-1:0] ldv, cnt;
    logic end_hit, take, new_req;
    seq_wait_counter #(.W(CW), .TERM(MAX_WAIT - 1)) u_cnt (
        .clk(clk), .reset(reset), .load(ld), .load_val(ldv), .dec(dec), .inc(inc),
        .cnt(cnt), .last(last), .term(term)
    );
    assign end_hit = pc_in >= ADDR_W'(PC_END_ADDRESS);
    assign take    = branch && zero;
    // a held load/store that already finished its stall must not stall again
    assign new_req = mem_req && !mem_served;
    always_ff @(posedge clk)
        if (reset) begin
            state      <= RUN;
            mem_served <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state      <= nxt;
            mem_served <= set_srv ? 1'b1 : clr_srv ? 1'b0 : mem_served;
            tmo_q      <= tmo_q | set_to;
        end
    always_comb begin
        nxt = state;
        ld = 1'b0;
        ldv = '0;
        dec = 1'b0;
        inc = 1'b0;
        set_srv = 1'b0;
        clr_srv = 1'b0;
        set_to = 1'b0;
        case (state)
            RUN:
                if (end_hit) nxt = HALT;
                else if (take) begin
                    clr_srv = 1'b1;
                    if (FLUSH_CYCLES > 0) begin
                        nxt = FLUSH;
                        ld = 1'b1;
                        ldv = CW'(FLUSH_CYCLES);
                    end
                end else if (new_req) begin
                    if (USE_READY != 0) begin
                        nxt = MEM_WAIT;
                        ld = 1'b1;
                    end else if (MEM_LATENCY == 1) set_srv = 1'b1;
                    else begin
                        nxt = MEM_WAIT;
                        ld = 1'b1;
                        ldv = CW'(MEM_LATENCY - 1);
                    end
                end else clr_srv = 1'b1;
            MEM_WAIT:
                if (USE_READY != 0) begin
                    if (mem_ready) begin
                        nxt = RUN;
                        set_srv = 1'b1;
                    end else if (term) begin
                        nxt = HALT;
                        set_to = 1'b1;
                    end else inc = 1'b1;
                end else if (last) begin
                    nxt = RUN;
                    set_srv = 1'b1;
                end else dec = 1'b1;
            FLUSH:
                if (end_hit) nxt = HALT;
                else if (last) nxt = RUN;
                else dec = 1'b1;
            default: ;
        endcase
    end
    always_comb begin
        pc_en       = !reset && ((state == RUN && !end_hit && !take && !new_req) || (state == FLUSH && !end_hit));
        pc_load     = !reset && state == RUN && !end_hit && take;
        stall       = !reset && (state == MEM_WAIT || (state == RUN && !end_hit && !take && new_req));
        flush       = !reset && state == FLUSH;
        halted      = !reset && state == HALT;
        timeout_err = !reset && tmo_q;
        pc_target   = reset ? '0 : offset + pc_in + ADDR_W'(1);
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of a fixed-latency and a ready-mode pc_sequencer
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic f_reset = 1'b1, r_reset = 1'b1;
    logic [31:0] pc_in = 32'd212, offset = '0;
    logic branch = 1'b0, zero = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic f_en, f_ld, f_st, f_fl, f_ha, f_to, r_en, r_ld, r_st, r_fl, r_ha, r_to;
    logic [31:0] f_tg, r_tg;
    logic [5:0] fo, ro;
    int vec = 0, errs = 0;
    always #5 clk = ~clk;
    pc_sequencer #(.USE_READY(0), .MEM_LATENCY(3), .MAX_WAIT(16), .FLUSH_CYCLES(1)) u_fix (
        .clk(clk), .reset(f_reset), .pc_in(pc_in), .branch(branch), .zero(zero), .offset(offset),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(f_en), .pc_load(f_ld), .pc_target(f_tg),
        .stall(f_st), .flush(f_fl), .halted(f_ha), .timeout_err(f_to)
    );
    pc_sequencer #(.USE_READY(1), .MEM_LATENCY(3), .MAX_WAIT(4), .FLUSH_CYCLES(1)) u_rdy (
        .clk(clk), .reset(r_reset), .pc_in(pc_in), .branch(branch), .zero(zero), .offset(offset),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(r_en), .pc_load(r_ld), .pc_target(r_tg),
        .stall(r_st), .flush(r_fl), .halted(r_ha), .timeout_err(r_to)
    );
    // output vectors ordered {pc_en, pc_load, stall, flush, halted, timeout_err}
    assign fo = {f_en, f_ld, f_st, f_fl, f_ha, f_to};
    assign ro = {r_en, r_ld, r_st, r_fl, r_ha, r_to};
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic nxt;
        @(negedge clk);
        #1;
    endtask
    initial begin
        nxt;
        chk("reset_out", {26'd0, fo}, 32'h00);
        chk("reset_tgt", f_tg, 32'd0);
        f_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc_in = 32'd212 + 32'(i);
            #1 chk($sformatf("line_%0d", i), {26'd0, fo}, 32'h20);
            nxt;
        end
        pc_in = 32'd220;
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("stall_%0d", i), {26'd0, fo}, 32'h08);
            nxt;
        end
        #1 chk("stall_done", {26'd0, fo}, 32'h20);
        nxt;
        pc_in = 32'd221;
        mem_req = 1'b0;
        #1 chk("after_stall", {26'd0, fo}, 32'h20);
        nxt;
        pc_in = 32'd230;
        offset = 32'd5;
        branch = 1'b1;
        zero = 1'b1;
        #1 chk("br_load", {26'd0, fo}, 32'h10);
        chk("br_target", f_tg, 32'd236);
        nxt;
        pc_in = 32'd236;
        branch = 1'b0;
        #1 chk("br_flush", {26'd0, fo}, 32'h24);
        nxt;
        pc_in = 32'd237;
        #1 chk("br_resume", {26'd0, fo}, 32'h20);
        nxt;
        pc_in = 32'd240;
        branch = 1'b1;
        mem_req = 1'b1;
        #1 chk("brwin_load", {26'd0, fo}, 32'h10);
        chk("brwin_target", f_tg, 32'd246);
        nxt;
        pc_in = 32'd246;
        branch = 1'b0;
        #1 chk("brwin_flush", {26'd0, fo}, 32'h24);
        nxt;
        #1 chk("brwin_req_stall", {26'd0, fo}, 32'h08);
        nxt;
        #1 chk("midwait_stall", {26'd0, fo}, 32'h08);
        f_reset = 1'b1;
        #1 chk("midwait_reset", {26'd0, fo}, 32'h00);
        nxt;
        f_reset = 1'b0;
        mem_req = 1'b0;
        #1 chk("post_reset_run", {26'd0, fo}, 32'h20);
        nxt;
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) nxt;
        #1 chk("served_set", {26'd0, fo}, 32'h20);
        f_reset = 1'b1;
        nxt;
        f_reset = 1'b0;
        #1 chk("served_cleared", {26'd0, fo}, 32'h08);
        nxt;
        mem_req = 1'b0;
        for (int i = 0; i < 2; i++) nxt;
        pc_in = 32'd255;
        #1 chk("end_detect", {26'd0, fo}, 32'h00);
        nxt;
        pc_in = 32'hFFFF_FFFF;
        offset = 32'd0;
        #1 chk("end_halt", {26'd0, fo}, 32'h02);
        chk("target_wrap", f_tg, 32'd0);
        nxt;
        pc_in = 32'd10;
        branch = 1'b1;
        mem_req = 1'b1;
        #1 chk("halt_held", {26'd0, fo}, 32'h02);
        nxt;
        branch = 1'b0;
        zero = 1'b0;
        pc_in = 32'd220;
        mem_ready = 1'b1;
        r_reset = 1'b0;
        #1 chk("rdy_ignored_in_run", {26'd0, ro}, 32'h08);
        nxt;
        #1 chk("rdy_wait_done", {26'd0, ro}, 32'h08);
        nxt;
        #1 chk("rdy_served", {26'd0, ro}, 32'h20);
        nxt;
        mem_req = 1'b0;
        mem_ready = 1'b0;
        #1 chk("rdy_run", {26'd0, ro}, 32'h20);
        nxt;
        mem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("rdy_wait_%0d", i), {26'd0, ro}, 32'h08);
            nxt;
        end
        #1 chk("rdy_timeout", {26'd0, ro}, 32'h03);
        nxt;
        r_reset = 1'b1;
        #1 chk("rdy_reset", {26'd0, ro}, 32'h00);
        nxt;
        r_reset = 1'b0;
        mem_req = 1'b0;
        #1 chk("rdy_after_reset", {26'd0, ro}, 32'h20);
        nxt;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
